// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// Registered 3-to-8 style line decoder (generalised to N-to-2^N) with
// three-input gating and an optional auto-scan mode.
//
// In direct mode (mode=0) the select input is captured into the index register
// on every enabled clock, so a new select appears on y one clock later.
//
// In scan mode (mode=1) a prescaler counts enabled clocks. Every PERIOD of
// them, the index advances by one. It returns to 0 once it has reached
// 'last', and wrap pulses for one cycle when that return happens.
//
// Parameters
//   N          select width; the decoder drives 2^N lines
//   PERIOD     enabled scan-mode clocks per index step (>= 1)
//   ACTIVE_LOW 1: selected line is 0 and all others are 1
//
// Ports
//   clk    in   1      single clock, all state changes on the rising edge
//   rst    in   1      synchronous reset, active-high, highest priority
//   g1     in   1      enable, active-high
//   g2a_n  in   1      enable, active-low
//   g2b_n  in   1      enable, active-low
//   mode   in   1      0 = direct decode, 1 = auto-scan
//   sel    in   N      direct-mode select
//   last   in   N      highest index visited in scan mode
//   y      out  2^N    decoded lines, derived only from registered state
//   idx    out  N      current registered index
//   wrap   out  1      one-cycle pulse after a scan step that returned to 0
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter int N          = 3,
  parameter int PERIOD     = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              g1,
  input  logic              g2a_n,
  input  logic              g2b_n,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  input  logic [N-1:0]      last,
  output logic [(1<<N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 1 << N;
  // The prescaler needs at least one bit even when PERIOD=1 (it then stays 0).
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(PERIOD - 1);
  localparam logic [N-1:0]  IDX_ZERO = {N{1'b0}};
  localparam logic [N-1:0]  IDX_ONE  = N'(1);
  localparam logic [N-1:0]  IDX_MAX  = {N{1'b1}};

  // One-hot decode of the index, gated by the enable and set to the
  // requested polarity.
  function automatic logic [W-1:0] decode_lines(input logic [N-1:0] sel_idx,
                                                input logic          line_en);
    logic [W-1:0] v;
    v = {W{1'b0}};
    if (line_en) begin
      v[sel_idx] = 1'b1;
    end else begin
      v = {W{1'b0}};
    end
    if (ACTIVE_LOW != 0) begin
      v = ~v;
    end else begin
      v = v;
    end
    return v;
  endfunction

  logic          en_s;
  logic          en_q_r;
  logic [N-1:0]  idx_r;
  logic [N-1:0]  idx_nxt_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic          wrap_r;
  logic          wrap_nxt_s;

  assign en_s = g1 & ~g2a_n & ~g2b_n;

  // Next-state logic for index, prescaler and wrap pulse.
  always_comb begin
    idx_nxt_s   = idx_r;
    presc_nxt_s = presc_r;
    wrap_nxt_s  = 1'b0;
    if (!mode) begin
      // Direct mode: the prescaler is held cleared so a later switch to
      // scan mode starts a full PERIOD from the current index.
      presc_nxt_s = PRE_ZERO;
      if (en_s) begin
        idx_nxt_s = sel;
      end else begin
        idx_nxt_s = idx_r;
      end
    end else if (en_s) begin
      if (presc_r == PRE_MAX) begin
        presc_nxt_s = PRE_ZERO;
        // The IDX_MAX term keeps the index in range even if last is ignored.
        if ((idx_r >= last) || (idx_r == IDX_MAX)) begin
          idx_nxt_s  = IDX_ZERO;
          wrap_nxt_s = 1'b1;
        end else begin
          idx_nxt_s  = idx_r + IDX_ONE;
        end
      end else begin
        presc_nxt_s = presc_r + PRE_ONE;
      end
    end else begin
      // Scan mode, disabled: everything holds.
      idx_nxt_s   = idx_r;
      presc_nxt_s = presc_r;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q_r  <= 1'b0;
      idx_r   <= IDX_ZERO;
      presc_r <= PRE_ZERO;
      wrap_r  <= 1'b0;
    end else begin
      en_q_r  <= en_s;
      idx_r   <= idx_nxt_s;
      presc_r <= presc_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign y    = decode_lines(idx_r, en_q_r);
  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//
// Directed self-checking bench for scan_decoder with N=3, PERIOD=4,
// ACTIVE_LOW=1. Inputs change 1 ns after a rising edge; outputs are sampled
// at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  logic       clk;
  logic       rst;
  logic       g1;
  logic       g2a_n;
  logic       g2b_n;
  logic       mode;
  logic [2:0] sel;
  logic [2:0] last;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  int n_cmp;
  int n_bad;

  // Expected active-low line pattern for each index, written out by hand.
  logic [7:0] exp_y [8];

  scan_decoder #(.N(3), .PERIOD(4), .ACTIVE_LOW(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .g1    (g1),
    .g2a_n (g2a_n),
    .g2b_n (g2b_n),
    .mode  (mode),
    .sel   (sel),
    .last  (last),
    .y     (y),
    .idx   (idx),
    .wrap  (wrap)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_y[0] = 8'hFE; exp_y[1] = 8'hFD; exp_y[2] = 8'hFB; exp_y[3] = 8'hF7;
    exp_y[4] = 8'hEF; exp_y[5] = 8'hDF; exp_y[6] = 8'hBF; exp_y[7] = 8'h7F;

    rst = 1'b1; g1 = 1'b0; g2a_n = 1'b1; g2b_n = 1'b1;
    mode = 1'b0; sel = 3'd0; last = 3'd7;

    // Reset
    step();
    rst = 1'b0;
    check_eq("rst_y", 32'(y), 32'h0000_00FF);
    check_eq("rst_idx", 32'(idx), 32'd0);
    check_eq("rst_wrap", 32'(wrap), 32'd0);

    // Direct decode of every select value
    g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      check_eq("dir_y", 32'(y), 32'(exp_y[s]));
      check_eq("dir_idx", 32'(idx), 32'(s));
      check_eq("dir_wrap", 32'(wrap), 32'd0);
    end

    // Enable gating: each enable alone forces lines inactive and holds idx
    sel = 3'd5;
    step();
    check_eq("gate_base_y", 32'(y), 32'h0000_00DF);
    for (int g = 0; g < 3; g++) begin
      g1 = (g == 0) ? 1'b0 : 1'b1;
      g2a_n = (g == 1) ? 1'b1 : 1'b0;
      g2b_n = (g == 2) ? 1'b1 : 1'b0;
      sel = 3'd2;
      step();
      check_eq("gate_off_y", 32'(y), 32'h0000_00FF);
      check_eq("gate_off_idx", 32'(idx), 32'd5);
    end
    g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0; sel = 3'd5;
    step();
    check_eq("gate_on_y", 32'(y), 32'h0000_00DF);

    // Full scan from index 0 with last=7
    sel = 3'd0;
    step();
    mode = 1'b1; last = 3'd7;
    for (int i = 1; i <= 32; i++) begin
      step();
      check_eq("scan_idx", 32'(idx), 32'((i / 4) % 8));
      check_eq("scan_wrap", 32'(wrap), (i == 32) ? 32'd1 : 32'd0);
      if ((i % 4) == 0) begin
        check_eq("scan_y", 32'(y), 32'(exp_y[(i / 4) % 8]));
      end
    end
    step();
    check_eq("scan_wrap_end", 32'(wrap), 32'd0);
    check_eq("scan_idx_hold", 32'(idx), 32'd0);

    // Lower last below the current index mid-scan
    run(19);
    check_eq("last_at5", 32'(idx), 32'd5);
    last = 3'd2;
    run(4);
    check_eq("last_idx0", 32'(idx), 32'd0);
    check_eq("last_wrap0", 32'(wrap), 32'd1);
    run(4);
    check_eq("last_idx1", 32'(idx), 32'd1);
    check_eq("last_wrap1", 32'(wrap), 32'd0);
    run(4);
    check_eq("last_idx2", 32'(idx), 32'd2);
    run(4);
    check_eq("last_idx0b", 32'(idx), 32'd0);
    check_eq("last_wrap0b", 32'(wrap), 32'd1);

    // Reset mid-scan at idx=4 with the prescaler at 2
    last = 3'd7;
    run(18);
    check_eq("mrst_pre_idx", 32'(idx), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_idx", 32'(idx), 32'd0);
    check_eq("mrst_y", 32'(y), 32'h0000_00FF);
    check_eq("mrst_wrap", 32'(wrap), 32'd0);
    run(3);
    check_eq("mrst_idx3", 32'(idx), 32'd0);
    check_eq("mrst_y3", 32'(y), 32'h0000_00FE);
    step();
    check_eq("mrst_idx4", 32'(idx), 32'd1);
    check_eq("mrst_wrap4", 32'(wrap), 32'd0);

    // Prescaler holds while scan mode is disabled
    run(2);
    g1 = 1'b0;
    run(5);
    check_eq("hold_idx", 32'(idx), 32'd1);
    check_eq("hold_y", 32'(y), 32'h0000_00FF);
    g1 = 1'b1;
    step();
    check_eq("hold_idx_b", 32'(idx), 32'd1);
    step();
    check_eq("hold_idx_c", 32'(idx), 32'd2);
    check_eq("hold_y_c", 32'(y), 32'h0000_00FB);

    // Back to direct mode: first enabled cycle loads sel; loading 0 gives no wrap
    mode = 1'b0; sel = 3'd6;
    step();
    check_eq("s2d_idx", 32'(idx), 32'd6);
    check_eq("s2d_y", 32'(y), 32'h0000_00BF);
    sel = 3'd0;
    step();
    check_eq("s2d_idx0", 32'(idx), 32'd0);
    check_eq("s2d_wrap0", 32'(wrap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter N, default 3, select width; 2^N outputs.
REQ-002 SHALL have parameter PERIOD, default 4, scan-mode clocks per index step (>=1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, output polarity (1: selected line 0, others 1).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have port g1  in  1  enable, active-high.
REQ-007 SHALL have port g2a_n  in  1  enable, active-low.
REQ-008 SHALL have port g2b_n  in  1  enable, active-low.
REQ-009 SHALL have port mode  in  1  0 direct decode, 1 auto-scan.
REQ-010 SHALL have port sel  in  N  direct-mode select.
REQ-011 SHALL have port last  in  N  highest index visited in scan mode.
REQ-012 SHALL have port y  out  2^N  decoded outputs, registered-state driven.
REQ-013 SHALL have port idx  out  N  current registered index.
REQ-014 SHALL have port wrap  out  1  one-cycle pulse on scan wrap to 0.

Function
REQ-015 SHALL compute en = g1 & ~g2a_n & ~g2b_n combinationally each cycle.
REQ-016 SHALL register en into en_q every cycle.
REQ-017 SHALL drive y from idx and en_q only: en_q=1 -> one-hot at bit idx; en_q=0 -> all lines inactive; ACTIVE_LOW=1 inverts all bits.
REQ-018 SHALL hold idx when en=0, in both modes.
REQ-019 SHALL, in direct mode with en=1, load idx <= sel each cycle; sel-to-y latency 1 clock.
REQ-020 SHALL clear the prescaler to 0 whenever mode=0.
REQ-021 SHALL, in scan mode with en=1, increment the prescaler; tick when it equals PERIOD-1, then return it to 0.
REQ-022 SHALL hold the prescaler when mode=1 and en=0.
REQ-023 SHALL, on tick, set idx <= 0 if idx >= last, else idx+1.
REQ-024 SHALL assert wrap for exactly the one cycle following a tick that set idx to 0; wrap=0 otherwise, including direct-mode loads of 0.
REQ-025 SHALL, when last is lowered below idx mid-scan, take the next tick to 0 with wrap.
REQ-026 SHALL, with PERIOD=1, tick on every enabled scan-mode cycle.
REQ-027 SHALL, on direct->scan switch, resume scanning from current idx with prescaler at 0.
REQ-028 SHALL, on scan->direct switch, load sel on the first enabled direct cycle.
REQ-029 SHALL keep idx within 0..2^N-1; increment from 2^N-1 wraps to 0 regardless of last.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set idx=0, prescaler=0, en_q=0, wrap=0, so y is all inactive (all 1s when ACTIVE_LOW=1).
REQ-031 SHALL give rst priority over every other input, including mid-scan and during an active tick.

Verification (N=3, PERIOD=4, ACTIVE_LOW=1)
REQ-032 SHALL cover reset: rst=1 one clock -> y=8'hFF, idx=0, wrap=0.
REQ-033 SHALL cover direct decode: g1=1, g2a_n=0, g2b_n=0, mode=0, sel=0..7 -> one clock later y=FE, FD, FB, F7, EF, DF, BF, 7F.
REQ-034 SHALL cover enable gating: sel=5, each of g1=0 / g2a_n=1 / g2b_n=1 alone -> next clock y=FF, idx held; restore enables -> y=DF.
REQ-035 SHALL cover full scan: mode=1, last=7 -> idx steps every 4 clocks 0..7 then 0; y walks FE..7F; wrap high exactly one cycle at 7->0.
REQ-036 SHALL cover last change: at idx=5 set last=2 -> next tick idx=0, wrap=1; then cycle 0,1,2,0.
REQ-037 SHALL cover mid-scan reset: rst=1 at idx=4, prescaler=2 -> next clock idx=0, y=FF, wrap=0; first step 4 enabled clocks after rst release.
